// File: rtl/lockin_pkg.sv
// Shared widths, FSM state type and the shift-then-saturate helper for the lock-in demodulator.
package lockin_pkg;

  localparam int SIG_W    = 14;
  localparam int PROD_W   = 28;
  localparam int ACC_W    = 54;
  localparam int CNT_W    = 27;
  localparam int HARM_LEN = 2520;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Arithmetic shift (floors toward -inf), then clamp to a signed i_out_w-bit range.
  function automatic logic signed [ACC_W-1:0] sat_shift(
    input logic signed [ACC_W-1:0] i_v,
    input int                      i_shift,
    input int                      i_out_w
  );
    logic signed [ACC_W-1:0] w_one;
    logic signed [ACC_W-1:0] w_s;
    logic signed [ACC_W-1:0] w_hi;
    logic signed [ACC_W-1:0] w_lo;
    w_one = {{(ACC_W-1){1'b0}}, 1'b1};
    w_s   = i_v >>> i_shift;
    w_hi  = (w_one <<< (i_out_w - 1)) - w_one;
    w_lo  = ~w_hi;
    if (w_s > w_hi) begin
      return w_hi;
    end else if (w_s < w_lo) begin
      return w_lo;
    end
    return w_s;
  endfunction

endpackage

// File: rtl/lockin_mac.sv
// One demodulation channel: registered product, period accumulator and shifted/saturated dump register.
// Accumulate/clear/dump are commanded by the owning FSM; no backpressure.
module lockin_mac
  import lockin_pkg::*;
#(
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic signed [SIG_W-1:0] i_sig,
  input  logic signed [SIG_W-1:0] i_ref,
  input  logic                    i_add,
  input  logic                    i_clr,
  input  logic                    i_dump,
  output logic signed [OUT_W-1:0] o_res
);

  logic signed [PROD_W-1:0] w_sig_x;
  logic signed [PROD_W-1:0] w_ref_x;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_prod_x;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_sat;
  logic signed [OUT_W-1:0]  r_res;

  assign w_sig_x  = {{(PROD_W-SIG_W){i_sig[SIG_W-1]}}, i_sig};
  assign w_ref_x  = {{(PROD_W-SIG_W){i_ref[SIG_W-1]}}, i_ref};
  assign w_prod_x = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
  // The trigger sample itself belongs to the period, so the dump includes it.
  assign w_sum    = r_acc + w_prod_x;
  assign w_sat    = sat_shift(w_sum, OUT_SHIFT, OUT_W);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_prod <= '0;
      r_acc  <= '0;
      r_res  <= '0;
    end else begin
      r_prod <= w_sig_x * w_ref_x;
      if (i_dump || i_clr) begin
        r_acc <= '0;
      end else if (i_add) begin
        r_acc <= w_sum;
      end
      if (i_dump) begin
        r_res <= w_sat[OUT_W-1:0];
      end
    end
  end

  assign o_res = r_res;

endmodule

// File: rtl/lockin_demod.sv
// Period-synchronous lock-in demodulator: integrates sig*cos and sig*sin between triggers, dumps X/Y/count.
// Latency trig -> out_valid is 3 cycles; streaming one sample per cycle, no backpressure.
module lockin_demod
  import lockin_pkg::*;
#(
  parameter int OUT_W       = 32,
  parameter int OUT_SHIFT   = 0,
  parameter int MAX_SAMPLES = 41287680
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic signed [SIG_W-1:0] sig_in,
  input  logic signed [SIG_W-1:0] ref_cos,
  input  logic signed [SIG_W-1:0] ref_sin,
  input  logic                    trig,
  output logic signed [OUT_W-1:0] x_out,
  output logic signed [OUT_W-1:0] y_out,
  output logic [CNT_W-1:0]        n_samples,
  output logic                    out_valid,
  output logic                    err_timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

  logic signed [SIG_W-1:0] r_sig1;
  logic signed [SIG_W-1:0] r_cos1;
  logic signed [SIG_W-1:0] r_sin1;
  logic                    r_trig1;
  logic                    r_en1;
  logic                    r_trig2;
  logic                    r_en2;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] r_n;
  logic             r_valid;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_add;
  logic             w_clr;
  logic             w_dump;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sig1  <= '0;
      r_cos1  <= '0;
      r_sin1  <= '0;
      r_trig1 <= 1'b0;
      r_en1   <= 1'b0;
      r_trig2 <= 1'b0;
      r_en2   <= 1'b0;
    end else begin
      r_sig1  <= sig_in;
      r_cos1  <= ref_cos;
      r_sin1  <= ref_sin;
      r_trig1 <= trig;
      r_en1   <= en;
      r_trig2 <= r_trig1;
      r_en2   <= r_en1;
    end
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // A pending timeout holds the FSM in IDLE until enable is cycled, which keeps
  // err_timeout and out_valid from ever being high together.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_add       = 1'b0;
    w_clr       = 1'b0;
    w_dump      = 1'b0;
    if (!r_en2) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_err_nxt   = 1'b0;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          w_clr     = 1'b1;
          if (r_trig2 && !r_err) begin
            w_state_nxt = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (r_trig2) begin
            w_dump    = 1'b1;
            w_cnt_nxt = '0;
          end else if (w_cnt_inc == MAX_CNT) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_clr       = 1'b1;
          end else begin
            w_add     = 1'b1;
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_dump;
      r_err   <= w_err_nxt;
      if (w_dump) begin
        r_n <= w_cnt_inc;
      end
    end
  end

  lockin_mac #(
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac_x (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_sig  (r_sig1),
    .i_ref  (r_cos1),
    .i_add  (w_add),
    .i_clr  (w_clr),
    .i_dump (w_dump),
    .o_res  (x_out)
  );

  lockin_mac #(
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac_y (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_sig  (r_sig1),
    .i_ref  (r_sin1),
    .i_add  (w_add),
    .i_clr  (w_clr),
    .i_dump (w_dump),
    .o_res  (y_out)
  );

  assign n_samples   = r_n;
  assign out_valid   = r_valid;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_lockin_demod.sv
// Cycle-accurate scoreboard bench for lockin_demod: a per-sample reference model queues the
// expected output state, which is popped three cycles later when the DUT presents it.
module tb_lockin_demod;

  localparam int OW   = 32;
  localparam int SH   = 0;
  localparam int MAXS = 3000;

  logic                 clk     = 1'b0;
  logic                 rstn    = 1'b0;
  logic                 en      = 1'b0;
  logic                 trig    = 1'b0;
  logic signed [13:0]   sig_in  = '0;
  logic signed [13:0]   ref_cos = '0;
  logic signed [13:0]   ref_sin = '0;
  logic signed [OW-1:0] x_out;
  logic signed [OW-1:0] y_out;
  logic [26:0]          n_samples;
  logic                 out_valid;
  logic                 err_timeout;

  always #5 clk = ~clk;

  lockin_demod #(
    .OUT_W       (OW),
    .OUT_SHIFT   (SH),
    .MAX_SAMPLES (MAXS)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .sig_in      (sig_in),
    .ref_cos     (ref_cos),
    .ref_sin     (ref_sin),
    .trig        (trig),
    .x_out       (x_out),
    .y_out       (y_out),
    .n_samples   (n_samples),
    .out_valid   (out_valid),
    .err_timeout (err_timeout)
  );

  typedef struct {
    bit     v;
    bit     e;
    longint x;
    longint y;
    longint n;
  } exp_t;

  exp_t   sb[$];
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;

  bit     m_act, m_err;
  longint m_ax, m_ay, m_cnt, m_x, m_y, m_n;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint a);
    longint s, hi, lo;
    s  = a >>> SH;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  task automatic model_clear();
    m_act = 0; m_err = 0;
    m_ax = 0; m_ay = 0; m_cnt = 0;
    m_x = 0; m_y = 0; m_n = 0;
  endtask

  task automatic model(input int s, input int c, input int sn, input bit t, input bit e, output exp_t ex);
    longint pc, ps;
    pc = longint'(s) * longint'(c);
    ps = longint'(s) * longint'(sn);
    ex.v = 0;
    if (!e) begin
      m_act = 0; m_err = 0; m_ax = 0; m_ay = 0; m_cnt = 0;
    end else if (!m_act) begin
      if (t && !m_err) m_act = 1;
    end else if (t) begin
      m_x = sat(m_ax + pc);
      m_y = sat(m_ay + ps);
      m_n = m_cnt + 1;
      ex.v = 1;
      m_ax = 0; m_ay = 0; m_cnt = 0;
    end else if (m_cnt + 1 == MAXS) begin
      m_err = 1; m_act = 0; m_ax = 0; m_ay = 0; m_cnt = 0;
    end else begin
      m_ax += pc; m_ay += ps; m_cnt++;
    end
    ex.e = m_err;
    ex.x = m_x;
    ex.y = m_y;
    ex.n = m_n;
  endtask

  // Called just after a rising edge: drive one sample, then check what the DUT shows this cycle.
  task automatic step(input int s, input int c, input int sn, input bit t, input bit e);
    exp_t ex;
    exp_t cur;
    sig_in  = s[13:0];
    ref_cos = c[13:0];
    ref_sin = sn[13:0];
    trig    = t;
    en      = e;
    model(s, c, sn, t, e, ex);
    sb.push_back(ex);
    @(negedge clk);
    cur = sb.pop_front();
    chk("out_valid", out_valid, cur.v);
    chk("err_timeout", err_timeout, cur.e);
    chk("valid_err_excl", out_valid & err_timeout, 0);
    if (cur.v || cur.e || (cyc % 50 == 0)) begin
      chk("x_out", x_out, cur.x);
      chk("y_out", y_out, cur.y);
      chk("n_samples", n_samples, cur.n);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    exp_t z;
    rstn = 1'b0; en = 1'b0; trig = 1'b0;
    sig_in = '0; ref_cos = '0; ref_sin = '0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_n", n_samples, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", err_timeout, 0);
    rstn = 1'b1;
    model_clear();
    sb.delete();
    z.v = 0; z.e = 0; z.x = 0; z.y = 0; z.n = 0;
    repeat (3) sb.push_back(z);
  endtask

  task automatic run_const(input int s, input int c, input int sn, input int per, input int nper);
    for (int p = 0; p < nper; p++)
      for (int k = 0; k < per; k++)
        step(s, c, sn, (k == per - 1), 1'b1);
  endtask

  task automatic drain(input bit e);
    repeat (3) step(0, 0, 0, 1'b0, e);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint gx, gy;
    model_clear();
    do_reset(2);

    run_const(100, 200, -50, 10, 5);
    drain(1'b1);
    chk("const_x", x_out, 200000);
    chk("const_y", y_out, -50000);
    chk("const_n", n_samples, 10);

    for (int k = 0; k < 8; k++) step(7, -3, 5, 1'b1, 1'b1);
    drain(1'b1);
    chk("b2b_n", n_samples, 1);
    chk("b2b_x", x_out, -21);

    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 2520; k++) begin
        int c, sn;
        c  = $rtoi(600.0 * $cos(6.283185307179586 * k / 2520.0));
        sn = $rtoi(600.0 * $sin(6.283185307179586 * k / 2520.0));
        step(c, c, sn, (k == 2519), 1'b1);
      end
    end
    drain(1'b1);
    gx = x_out;
    gy = (y_out < 0) ? -longint'(y_out) : longint'(y_out);
    chk("gen_x_pos", (gx > 0), 1);
    chk("gen_y_small", (gy * 100 < gx), 1);
    chk("gen_n", n_samples, 2520);

    run_const(-8192, -8192, 8191, 40, 3);
    drain(1'b1);
    chk("sat_x", x_out, 64'sh7FFFFFFF);
    chk("sat_y", y_out, -64'sd2147483648);

    run_const(10, 10, -10, 10, 2);
    for (int k = 0; k < MAXS + 10; k++) step(10, 10, -10, 1'b0, 1'b1);
    chk("to_err", err_timeout, 1);
    chk("to_hold_x", x_out, 1000);
    chk("to_hold_y", y_out, -1000);
    chk("to_hold_n", n_samples, 10);
    repeat (4) step(0, 0, 0, 1'b0, 1'b0);
    chk("to_err_clr", err_timeout, 0);

    step(3, 4, 5, 1'b1, 1'b1);
    repeat (5) step(3, 4, 5, 1'b0, 1'b1);
    repeat (3) step(3, 4, 5, 1'b0, 1'b0);
    run_const(3, 4, 5, 12, 3);
    drain(1'b1);
    chk("endrop_n", n_samples, 12);
    chk("endrop_x", x_out, 144);

    run_const(9, 9, 9, 20, 1);
    repeat (7) step(9, 9, 9, 1'b0, 1'b1);
    do_reset(1);
    for (int k = 0; k < 10; k++) step(k + 1, 2, -1, 1'b1, 1'b1);
    drain(1'b1);
    chk("rst_b2b_n", n_samples, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
